axi_wr_arbiter: RTL

Write-path arbiter sharing one AXI slave port among up to 16 AXI masters, matching the 16-entry master array of the AXI environment. Round-robin over AW requests; the W channel stays locked to the granted master until its WLAST beat; B responses return to the originating master through a 4-bit master-index tag prepended to the slave-side ID. Sits between the master VIP interfaces and one slave interface as the shared-resource controller.

---
 rtl/axi_wr_arb_pkg.sv | 23 ++
 rtl/axi_rr_arbiter.sv | 32 +++
 rtl/axi_wr_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/axi_wr_arb_pkg.sv
// Shared constants, FSM state type and index helper for the AXI write-path arbiter.
package axi_wr_arb_pkg;

    localparam int unsigned MAX_MST = 16;
    localparam int unsigned IDX_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_e;

    // Reduce a sum of two in-range indices modulo n (sum < 2*n, so one subtraction suffices).
    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W:0] sum, input int unsigned n);
        logic [IDX_W:0] lim;
        lim = (IDX_W+1)'(n);
        if (sum >= lim) begin
            return IDX_W'(sum - lim);
        end
        return IDX_W'(sum);
    endfunction

endpackage

// File: rtl/axi_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after rr_ptr, wrapping at MST_NUM.
module axi_rr_arbiter
    import axi_wr_arb_pkg::*;
#(
    parameter int unsigned MST_NUM = 4
) (
    input  logic [MST_NUM-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_vld
);

    logic [MAX_MST-1:0] req_pad;
    logic [IDX_W-1:0]   cand;

    assign req_pad = MAX_MST'(req);

    // Scan lanes starting at the pointer; the first hit wins.
    always_comb begin
        grant_idx = '0;
        grant_vld = 1'b0;
        cand      = '0;
        for (int unsigned k = 0; k < MST_NUM; k++) begin
            cand = wrap_idx({1'b0, rr_ptr} + (IDX_W+1)'(k), MST_NUM);
            if (!grant_vld && req_pad[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Write-path arbiter: N AXI masters onto one slave port, round-robin on AW,
// W locked to the granted master until WLAST, B routed back by the ID index tag.
module axi_wr_arbiter
    import axi_wr_arb_pkg::*;
#(
    parameter int unsigned MST_NUM = 4,
    parameter int unsigned ID_W    = 4,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    // master-side AW
    input  logic [MST_NUM-1:0]             s_awvalid,
    output logic [MST_NUM-1:0]             s_awready,
    input  logic [MST_NUM*ID_W-1:0]        s_awid,
    input  logic [MST_NUM*ADDR_W-1:0]      s_awaddr,
    input  logic [MST_NUM*8-1:0]           s_awlen,
    // master-side W
    input  logic [MST_NUM-1:0]             s_wvalid,
    output logic [MST_NUM-1:0]             s_wready,
    input  logic [MST_NUM*DATA_W-1:0]      s_wdata,
    input  logic [MST_NUM*(DATA_W/8)-1:0]  s_wstrb,
    input  logic [MST_NUM-1:0]             s_wlast,
    // master-side B
    output logic [MST_NUM-1:0]             s_bvalid,
    input  logic [MST_NUM-1:0]             s_bready,
    output logic [ID_W-1:0]                s_bid,
    output logic [1:0]                     s_bresp,
    // slave-side AW
    output logic                           m_awvalid,
    input  logic                           m_awready,
    output logic [ID_W+3:0]                m_awid,
    output logic [ADDR_W-1:0]              m_awaddr,
    output logic [7:0]                     m_awlen,
    // slave-side W
    output logic                           m_wvalid,
    input  logic                           m_wready,
    output logic [DATA_W-1:0]              m_wdata,
    output logic [DATA_W/8-1:0]            m_wstrb,
    output logic                           m_wlast,
    // slave-side B
    input  logic                           m_bvalid,
    output logic                           m_bready,
    input  logic [ID_W+3:0]                m_bid,
    input  logic [1:0]                     m_bresp,
    output logic                           bid_err
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned SID_W  = ID_W + IDX_W;

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             bid_err_q, bid_err_d;

    logic [IDX_W-1:0] arb_idx;
    logic             arb_vld;

    // Lane payloads padded to the full index range so a 4-bit grant can index them directly.
    logic [ID_W-1:0]    aw_id_a   [MAX_MST];
    logic [ADDR_W-1:0]  aw_addr_a [MAX_MST];
    logic [7:0]         aw_len_a  [MAX_MST];
    logic [DATA_W-1:0]  w_data_a  [MAX_MST];
    logic [STRB_W-1:0]  w_strb_a  [MAX_MST];
    logic [MAX_MST-1:0] wvalid_pad, wlast_pad, bready_pad;
    logic [MAX_MST-1:0] awready_pad, wready_pad, bvalid_pad;
    logic [IDX_W-1:0]   b_idx;

    assign wvalid_pad = MAX_MST'(s_wvalid);
    assign wlast_pad  = MAX_MST'(s_wlast);
    assign bready_pad = MAX_MST'(s_bready);

    assign s_awready = MST_NUM'(awready_pad);
    assign s_wready  = MST_NUM'(wready_pad);
    assign s_bvalid  = MST_NUM'(bvalid_pad);
    assign bid_err   = bid_err_q;

    // Unpack per-lane payload slices; lanes beyond MST_NUM read as zero.
    for (genvar g = 0; g < MAX_MST; g++) begin : g_lane
        if (g < MST_NUM) begin : g_used
            assign aw_id_a[g]   = s_awid[g*ID_W +: ID_W];
            assign aw_addr_a[g] = s_awaddr[g*ADDR_W +: ADDR_W];
            assign aw_len_a[g]  = s_awlen[g*8 +: 8];
            assign w_data_a[g]  = s_wdata[g*DATA_W +: DATA_W];
            assign w_strb_a[g]  = s_wstrb[g*STRB_W +: STRB_W];
        end else begin : g_unused
            assign aw_id_a[g]   = '0;
            assign aw_addr_a[g] = '0;
            assign aw_len_a[g]  = '0;
            assign w_data_a[g]  = '0;
            assign w_strb_a[g]  = '0;
        end
    end

    axi_rr_arbiter #(
        .MST_NUM (MST_NUM)
    ) u_rr (
        .req       (s_awvalid),
        .rr_ptr    (rr_ptr_q),
        .grant_idx (arb_idx),
        .grant_vld (arb_vld)
    );

    // State, grant, pointer and error pulse registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            bid_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            bid_err_q <= bid_err_d;
        end
    end

    // Next-state logic and AW/W forwarding from the granted lane.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        m_awvalid   = 1'b0;
        m_awid      = '0;
        m_awaddr    = '0;
        m_awlen     = '0;
        awready_pad = '0;
        m_wvalid    = 1'b0;
        m_wdata     = '0;
        m_wstrb     = '0;
        m_wlast     = 1'b0;
        wready_pad  = '0;
        case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    grant_d = arb_idx;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                m_awvalid            = 1'b1;
                m_awid               = {grant_q, aw_id_a[grant_q]};
                m_awaddr             = aw_addr_a[grant_q];
                m_awlen              = aw_len_a[grant_q];
                awready_pad[grant_q] = m_awready;
                if (m_awready) begin
                    rr_ptr_d = wrap_idx({1'b0, grant_q} + (IDX_W+1)'(1), MST_NUM);
                    state_d  = DATA;
                end
            end
            DATA: begin
                m_wvalid            = wvalid_pad[grant_q];
                m_wdata             = w_data_a[grant_q];
                m_wstrb             = w_strb_a[grant_q];
                m_wlast             = wlast_pad[grant_q];
                wready_pad[grant_q] = m_wready;
                if (m_wvalid && m_wready && m_wlast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // B response routing by the index tag in the upper ID bits; bad tags are sunk.
    always_comb begin
        b_idx      = m_bid[SID_W-1 -: IDX_W];
        bvalid_pad = '0;
        m_bready   = 1'b1;
        bid_err_d  = 1'b0;
        s_bid      = m_bid[ID_W-1:0];
        s_bresp    = m_bresp;
        if ({1'b0, b_idx} < (IDX_W+1)'(MST_NUM)) begin
            bvalid_pad[b_idx] = m_bvalid;
            m_bready          = bready_pad[b_idx];
        end else begin
            bid_err_d = m_bvalid;
        end
    end

endmodule
